// File: rtl/signed_div_sequencer_pkg.sv
// Shared types and sign helpers for the signed divide sequencer.
// Helpers work on a 64-bit word; callers size-cast to WIDTH.
package signed_div_pkg;

    localparam int MAXW = 64;

    typedef logic [MAXW-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DIV,
        FIXUP,
        RESULT
    } state_t;

    function automatic word_t cond_neg(input word_t v, input logic neg);
        return neg ? (~v + word_t'(1)) : v;
    endfunction

    function automatic word_t magnitude(input word_t v, input logic msb,
                                        input logic is_signed);
        return cond_neg(v, is_signed & msb);
    endfunction

endpackage

// File: rtl/signed_div_sequencer_if.sv
// Request, response and divider-core signals of the signed divide sequencer.
// slave = sequencer view, master = surrounding datapath / core view.
interface signed_div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_div_by_zero;
    logic             out_overflow;
    logic             div_go;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_divide_by_zero;

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor,
        input  out_ready,
        input  div_done, div_quotient, div_remainder, div_divide_by_zero,
        output in_ready,
        output out_valid, out_quotient, out_remainder,
        output out_div_by_zero, out_overflow,
        output div_go, div_dividend, div_divisor
    );

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor,
        output out_ready,
        output div_done, div_quotient, div_remainder, div_divide_by_zero,
        input  in_ready,
        input  out_valid, out_quotient, out_remainder,
        input  out_div_by_zero, out_overflow,
        input  div_go, div_dividend, div_divisor
    );
endinterface

// File: rtl/signed_div_sequencer_fixup.sv
// Combinational sign correction and zero/overflow conventions
// applied to the unsigned core result.
module sdiv_sign_fixup
    import signed_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] q_raw,
    input  logic [WIDTH-1:0] r_raw,
    input  logic [WIDTH-1:0] dvd_orig,
    input  logic             dz,
    input  logic             ovf,
    input  logic             q_neg,
    input  logic             r_neg,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dz_flag,
    output logic             ovf_flag
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        q        = WIDTH'(cond_neg(word_t'(q_raw), q_neg));
        r        = WIDTH'(cond_neg(word_t'(r_raw), r_neg));
        dz_flag  = 1'b0;
        ovf_flag = 1'b0;
        // Divide-by-zero outranks overflow.
        if (dz) begin
            q       = '1;
            r       = dvd_orig;
            dz_flag = 1'b1;
        end else if (ovf) begin
            q        = MIN;
            r        = '0;
            ovf_flag = 1'b1;
        end
    end
endmodule

// File: rtl/signed_div_sequencer.sv
// Signed/unsigned front-end around an unsigned iterative divider core.
// Optional SDIV_FASTPATH_EN: divisor magnitude 1 bypasses the core.
module signed_div_sequencer
    import signed_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    signed_div_sequencer_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             q_neg, r_neg, ovf, dz_raw;
    logic [WIDTH-1:0] dvd_orig, q_raw, r_raw;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] fx_q, fx_r;
    logic             fx_dz, fx_ovf;

    assign a_mag = WIDTH'(magnitude(word_t'(bus.in_dividend),
                                    bus.in_dividend[WIDTH-1],
                                    bus.in_signed));
    assign b_mag = WIDTH'(magnitude(word_t'(bus.in_divisor),
                                    bus.in_divisor[WIDTH-1],
                                    bus.in_signed));

    sdiv_sign_fixup #(.WIDTH(WIDTH)) u_fixup (
        .q_raw    (q_raw),
        .r_raw    (r_raw),
        .dvd_orig (dvd_orig),
        .dz       (dz_raw),
        .ovf      (ovf),
        .q_neg    (q_neg),
        .r_neg    (r_neg),
        .q        (fx_q),
        .r        (fx_r),
        .dz_flag  (fx_dz),
        .ovf_flag (fx_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            q_neg               <= 1'b0;
            r_neg               <= 1'b0;
            ovf                 <= 1'b0;
            dz_raw              <= 1'b0;
            dvd_orig            <= '0;
            q_raw               <= '0;
            r_raw               <= '0;
            bus.in_ready        <= 1'b1;
            bus.out_valid       <= 1'b0;
            bus.out_quotient    <= '0;
            bus.out_remainder   <= '0;
            bus.out_div_by_zero <= 1'b0;
            bus.out_overflow    <= 1'b0;
            bus.div_go          <= 1'b0;
            bus.div_dividend    <= '0;
            bus.div_divisor     <= '0;
        end else begin
            bus.div_go <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        q_neg <= bus.in_signed &
                                 (bus.in_dividend[WIDTH-1] ^
                                  bus.in_divisor[WIDTH-1]);
                        r_neg <= bus.in_signed & bus.in_dividend[WIDTH-1];
                        ovf   <= bus.in_signed &
                                 (bus.in_dividend == MIN) &
                                 (bus.in_divisor == '1);
                        dvd_orig         <= bus.in_dividend;
                        bus.div_dividend <= a_mag;
                        bus.div_divisor  <= b_mag;
                        bus.in_ready     <= 1'b0;
`ifdef SDIV_FASTPATH_EN
                        if (b_mag == WIDTH'(1)) begin
                            q_raw  <= a_mag;
                            r_raw  <= '0;
                            dz_raw <= 1'b0;
                            state  <= FIXUP;
                        end else begin
                            bus.div_go <= 1'b1;
                            state      <= ISSUE;
                        end
`else
                        bus.div_go <= 1'b1;
                        state      <= ISSUE;
`endif
                    end
                end
                ISSUE: state <= WAIT_DIV;
                WAIT_DIV: begin
                    if (bus.div_done) begin
                        q_raw  <= bus.div_quotient;
                        r_raw  <= bus.div_remainder;
                        dz_raw <= bus.div_divide_by_zero;
                        state  <= FIXUP;
                    end
                end
                FIXUP: begin
                    bus.out_quotient    <= fx_q;
                    bus.out_remainder   <= fx_r;
                    bus.out_div_by_zero <= fx_dz;
                    bus.out_overflow    <= fx_ovf;
                    bus.out_valid       <= 1'b1;
                    state               <= RESULT;
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_div_sequencer.sv
// Bench for signed_div_sequencer (WIDTH=8) with a behavioural unsigned
// divider core, directed vectors, corner sequences and random requests.
module tb_signed_div_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    signed_div_sequencer_if #(.WIDTH(W)) bus ();

    signed_div_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int go_cnt  = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.div_go) go_cnt <= go_cnt + 1;
    always @(posedge clk) if (bus.div_done) done_cyc <= cyc;

    // Unsigned divider core: random latency, one-cycle done pulse.
    logic       core_done, stray_done, busy;
    int         cnt;
    logic [7:0] ca, cb;
    assign bus.div_done = core_done | stray_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt <= 0;
            core_done <= 1'b0;
            ca <= '0;
            cb <= '0;
            bus.div_quotient <= '0;
            bus.div_remainder <= '0;
            bus.div_divide_by_zero <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (bus.div_go) begin
                busy <= 1'b1;
                cnt <= int'($urandom_range(0, 6));
                ca <= bus.div_dividend;
                cb <= bus.div_divisor;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy <= 1'b0;
                    core_done <= 1'b1;
                    bus.div_quotient <= (cb == 0) ? 8'hFF : ca / cb;
                    bus.div_remainder <= (cb == 0) ? ca : ca % cb;
                    bus.div_divide_by_zero <= (cb == 0);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: integer division truncating toward zero.
    task automatic ref_div(input logic s, input logic [7:0] a, b,
                           output logic [7:0] q, r,
                           output logic dz, ov);
        int ai, bi;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 8'h00) begin
            q = 8'hFF;
            r = a;
            dz = 1'b1;
        end else if (s && a == 8'h80 && b == 8'hFF) begin
            q = 8'h80;
            r = 8'h00;
            ov = 1'b1;
        end else begin
            ai = s ? int'($signed(a)) : int'(a);
            bi = s ? int'($signed(b)) : int'(b);
            q = 8'(ai / bi);
            r = 8'(ai % bi);
        end
    endtask

    task automatic run_req(input logic s, input logic [7:0] a, b,
                           input int hold,
                           input logic [7:0] eq, er,
                           input logic edz, eov);
        int t, acc, g0;
        logic fast;
        fast = 1'b0;
`ifdef SDIV_FASTPATH_EN
        fast = (b == 8'h01) || (s && b == 8'hFF);
`endif
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_wait", 32'(t < 50), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_signed = s;
        bus.in_dividend = a;
        bus.in_divisor = b;
        acc = cyc;
        g0 = go_cnt;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        check("go_at_t1", 32'(bus.div_go), 32'(!fast));
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("result_wait", 32'(t < 100), 32'd1);
        if (fast) check("fast_latency", 32'(cyc - acc), 32'd2);
        else check("done_to_valid", 32'(cyc - done_cyc), 32'd2);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_signed = 1'b0;
            bus.in_dividend = 8'h11;
            bus.in_divisor = 8'h01;
            check("hold_flags", {30'd0, bus.out_valid, bus.in_ready},
                  32'd2);
            check("hold_q", 32'(bus.out_quotient), 32'(eq));
            check("hold_r", 32'(bus.out_remainder), 32'(er));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("quotient", 32'(bus.out_quotient), 32'(eq));
        check("remainder", 32'(bus.out_remainder), 32'(er));
        check("div_by_zero", 32'(bus.out_div_by_zero), 32'(edz));
        check("overflow", 32'(bus.out_overflow), 32'(eov));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("handshake", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        check("go_count", 32'(go_cnt - g0), fast ? 32'd0 : 32'd1);
    endtask

    typedef struct {
        logic       s;
        logic [7:0] a, b, q, r;
        logic       dz, ov;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       s, dz, ov;
        logic [7:0] a, b, q, r;

        vt[0]  = '{1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 8'h9C, 8'hFF, 8'h64, 8'h00, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0};
        vt[10] = '{1'b1, 8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0};
        vt[11] = '{1'b1, 8'h81, 8'h7F, 8'hFF, 8'h00, 1'b0, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor = '0;
        bus.out_ready = 1'b0;
        stray_done = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_outs", {bus.out_valid, bus.div_go, bus.out_div_by_zero,
                           bus.out_overflow, bus.out_quotient,
                           bus.out_remainder, 4'd0}, 32'd0);
        check("rst_core_ops", {16'd0, bus.div_dividend, bus.div_divisor},
              32'd0);
        rst = 1'b0;

        // A done pulse while idle must not produce a result.
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_done", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);

        for (int i = 0; i < 12; i++)
            run_req(vt[i].s, vt[i].a, vt[i].b, (i == 0) ? 5 : 0,
                    vt[i].q, vt[i].r, vt[i].dz, vt[i].ov);

        // Reset while the core is busy abandons the request.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_signed = 1'b1;
        bus.in_dividend = 8'h64;
        bus.in_divisor = 8'h03;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("rstw_go", 32'(bus.div_go), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_idle", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
        check("rstw_data", {bus.out_quotient, bus.out_remainder,
                            bus.div_dividend, bus.div_divisor}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rstw_no_result", 32'(bus.out_valid), 32'd0);
        run_req(1'b1, 8'h64, 8'h03, 0, 8'h21, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'h00;
                1: b = 8'h01;
                2: b = 8'hFF;
                3: a = 8'h80;
                default: ;
            endcase
            ref_div(s, a, b, q, r, dz, ov);
            run_req(s, a, b, int'($urandom_range(0, 3)), q, r, dz, ov);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
